// File: rtl/spw_rx_pkg.sv
// Shared constants and the FSM state type for the SpaceWire receive character buffer.
package spw_rx_pkg;

    // Control codes carried in char_code[1:0] when char_is_ctrl is set
    localparam logic [1:0] CtrlFct = 2'd0;
    localparam logic [1:0] CtrlEop = 2'd1;
    localparam logic [1:0] CtrlEep = 2'd2;
    localparam logic [1:0] CtrlEsc = 2'd3;

    // 9-bit FIFO entries for packet markers; data bytes are {1'b0, byte}
    localparam logic [8:0] FlagEop = 9'h100;
    localparam logic [8:0] FlagEep = 9'h101;

    typedef enum logic [1:0] {
        StIdle,
        StEscPend,
        StError
    } rx_state_e;

endpackage

// File: rtl/spw_rx_fifo.sv
// First-word-fall-through FIFO with occupancy output; simultaneous read and write
// are both honoured, including when full.
module spw_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 9,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_level
);

    localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_rd;
    logic             w_do_wr;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LvlFull);
    assign w_do_rd = i_rd_en && !w_empty;
    // A pop in the same cycle frees the slot the write needs
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    // Storage array; no reset needed since the head output is gated by empty
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_level   = r_level;

endmodule

// File: rtl/rx_char_buffer.sv
// Receive character buffer: decodes ESC sequences, buffers data/EOP/EEP in a FIFO,
// extracts time-codes and FCTs, and tracks sticky parity/escape/overflow errors.
module rx_char_buffer
    import spw_rx_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter bit          TC_ENABLE = 1'b1
) (
    input  logic                     posedge_clk,
    input  logic                     rx_resetn,
    input  logic                     char_valid,
    input  logic                     char_is_ctrl,
    input  logic [7:0]               char_code,
    input  logic                     parity_ok,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [8:0]               rx_data_flag,
    output logic                     rx_data_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               timecode,
    output logic                     timecode_valid,
    output logic                     rx_got_fct,
    output logic                     rx_error_par,
    output logic                     rx_error_esc,
    output logic                     rx_overflow
);

    rx_state_e  r_state;
    rx_state_e  w_state_d;
    logic [7:0] r_timecode;
    logic       r_tc_valid;
    logic       r_got_fct;
    logic       r_err_par;
    logic       r_err_esc;
    logic       r_overflow;

    logic       w_wr_req;
    logic [8:0] w_wr_data;
    logic       w_tc_load;
    logic       w_fct;
    logic       w_set_par;
    logic       w_set_esc;
    logic       w_set_ovf;
    logic       w_fifo_empty;
    logic       w_fifo_full;
    logic       w_can_write;
    logic       w_fifo_wr;

    // Full FIFO still accepts a write when the consumer pops the same cycle
    assign w_can_write = !w_fifo_full || rd_en;
    assign w_fifo_wr   = w_wr_req && w_can_write;
    assign w_set_ovf   = w_wr_req && !w_can_write;

    // Next-state decode; an error entry writes EEP in the same cycle it is detected
    always_comb begin
        w_state_d = r_state;
        w_wr_req  = 1'b0;
        w_wr_data = '0;
        w_tc_load = 1'b0;
        w_fct     = 1'b0;
        w_set_par = 1'b0;
        w_set_esc = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (char_valid) begin
                    if (!parity_ok) begin
                        w_set_par = 1'b1;
                        w_wr_req  = 1'b1;
                        w_wr_data = FlagEep;
                        w_state_d = StError;
                    end else if (!char_is_ctrl) begin
                        w_wr_req  = 1'b1;
                        w_wr_data = {1'b0, char_code};
                    end else begin
                        case (char_code[1:0])
                            CtrlFct: w_fct = 1'b1;
                            CtrlEop: begin
                                w_wr_req  = 1'b1;
                                w_wr_data = FlagEop;
                            end
                            CtrlEep: begin
                                w_wr_req  = 1'b1;
                                w_wr_data = FlagEep;
                            end
                            default: w_state_d = StEscPend;
                        endcase
                    end
                end
            end
            StEscPend: begin
                if (char_valid) begin
                    if (!parity_ok) begin
                        w_set_par = 1'b1;
                        w_wr_req  = 1'b1;
                        w_wr_data = FlagEep;
                        w_state_d = StError;
                    end else if (!char_is_ctrl && TC_ENABLE) begin
                        w_tc_load = 1'b1;
                        w_state_d = StIdle;
                    end else if (char_is_ctrl && char_code[1:0] == CtrlFct) begin
                        // ESC+FCT is a NULL: silently dropped
                        w_state_d = StIdle;
                    end else begin
                        w_set_esc = 1'b1;
                        w_wr_req  = 1'b1;
                        w_wr_data = FlagEep;
                        w_state_d = StError;
                    end
                end
            end
            StError: begin
                if (err_clr) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, pulses, time-code and sticky errors; a new error beats a same-cycle clear
    always_ff @(posedge posedge_clk) begin
        if (!rx_resetn) begin
            r_state    <= StIdle;
            r_timecode <= '0;
            r_tc_valid <= 1'b0;
            r_got_fct  <= 1'b0;
            r_err_par  <= 1'b0;
            r_err_esc  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_tc_valid <= w_tc_load;
            r_got_fct  <= w_fct;
            if (w_tc_load) r_timecode <= char_code;
            r_err_par  <= w_set_par | (r_err_par & ~err_clr);
            r_err_esc  <= w_set_esc | (r_err_esc & ~err_clr);
            r_overflow <= w_set_ovf | (r_overflow & ~err_clr);
        end
    end

    spw_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .i_clk     (posedge_clk),
        .i_rst_n   (rx_resetn),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (rd_en),
        .o_rd_data (rx_data_flag),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full),
        .o_level   (fifo_level)
    );

    assign rx_data_valid  = !w_fifo_empty;
    assign timecode       = r_timecode;
    assign timecode_valid = r_tc_valid;
    assign rx_got_fct     = r_got_fct;
    assign rx_error_par   = r_err_par;
    assign rx_error_esc   = r_err_esc;
    assign rx_overflow    = r_overflow;

endmodule

// File: tb/tb_rx_char_buffer.sv
// Scoreboard bench for rx_char_buffer: expected FIFO entries are queued as stimulus is
// issued and a negedge monitor compares each popped head against the queue.
module tb_rx_char_buffer;

    logic       clk = 1'b0;
    logic       rx_resetn = 1'b0;
    logic       char_valid = 1'b0;
    logic       char_is_ctrl = 1'b0;
    logic [7:0] char_code = '0;
    logic       parity_ok = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [8:0] rx_data_flag;
    logic       rx_data_valid;
    logic [3:0] fifo_level;
    logic [7:0] timecode;
    logic       timecode_valid;
    logic       rx_got_fct;
    logic       rx_error_par;
    logic       rx_error_esc;
    logic       rx_overflow;

    // Second instance with time-codes disabled
    logic       n_valid = 1'b0;
    logic       n_ctrl = 1'b0;
    logic [7:0] n_code = '0;
    logic [8:0] n_flag;
    logic       n_dvalid;
    logic [3:0] n_level;
    logic [7:0] n_tc;
    logic       n_tcv;
    logic       n_fct;
    logic       n_par;
    logic       n_esc;
    logic       n_ovf;

    int         checks = 0;
    int         errors = 0;
    int         tc_cnt = 0;
    int         fct_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;

    always #5 clk = ~clk;

    rx_char_buffer #(.DEPTH(8), .TC_ENABLE(1'b1)) dut (
        .posedge_clk    (clk),
        .rx_resetn      (rx_resetn),
        .char_valid     (char_valid),
        .char_is_ctrl   (char_is_ctrl),
        .char_code      (char_code),
        .parity_ok      (parity_ok),
        .rd_en          (rd_en),
        .err_clr        (err_clr),
        .rx_data_flag   (rx_data_flag),
        .rx_data_valid  (rx_data_valid),
        .fifo_level     (fifo_level),
        .timecode       (timecode),
        .timecode_valid (timecode_valid),
        .rx_got_fct     (rx_got_fct),
        .rx_error_par   (rx_error_par),
        .rx_error_esc   (rx_error_esc),
        .rx_overflow    (rx_overflow)
    );

    rx_char_buffer #(.DEPTH(8), .TC_ENABLE(1'b0)) dut_notc (
        .posedge_clk    (clk),
        .rx_resetn      (rx_resetn),
        .char_valid     (n_valid),
        .char_is_ctrl   (n_ctrl),
        .char_code      (n_code),
        .parity_ok      (1'b1),
        .rd_en          (1'b0),
        .err_clr        (1'b0),
        .rx_data_flag   (n_flag),
        .rx_data_valid  (n_dvalid),
        .fifo_level     (n_level),
        .timecode       (n_tc),
        .timecode_valid (n_tcv),
        .rx_got_fct     (n_fct),
        .rx_error_par   (n_par),
        .rx_error_esc   (n_esc),
        .rx_overflow    (n_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic c, input logic [7:0] code, input logic p,
                         input logic r, input logic e);
        @(posedge clk);
        #1;
        char_valid   = v;
        char_is_ctrl = c;
        char_code    = code;
        parity_ok    = p;
        rd_en        = r;
        err_clr      = e;
    endtask

    task automatic send_data(input logic [7:0] b);
        drive(1'b1, 1'b0, b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_ctrl(input logic [1:0] k);
        drive(1'b1, 1'b1, {6'd0, k}, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic r, input logic e);
        repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b1, r, e);
    endtask

    // Monitor: a pop happens at the next rising edge whenever rd_en meets a valid head
    initial begin
        forever begin
            @(negedge clk);
            if (rx_resetn && rd_en && rx_data_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected actual %03h required none", rx_data_flag);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rx_data_flag !== mon_exp) begin
                        errors++;
                        $display("FAIL head_pop actual %03h required %03h", rx_data_flag, mon_exp);
                    end
                end
            end
            if (timecode_valid) tc_cnt++;
            if (rx_got_fct) fct_cnt++;
        end
    end

    initial begin
        // Reset state
        idle(2, 1'b0, 1'b0);
        check("rst_flag", 32'(rx_data_flag), 32'h0);
        check("rst_valid", 32'(rx_data_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_tc", 32'(timecode), 32'h0);
        check("rst_errs", 32'({rx_error_par, rx_error_esc, rx_overflow}), 32'h0);
        rx_resetn = 1'b1;

        // Two data bytes then EOP
        exp_q.push_back(9'h011); send_data(8'h11);
        exp_q.push_back(9'h022); send_data(8'h22);
        exp_q.push_back(9'h100); send_ctrl(2'd1);
        idle(1, 1'b0, 1'b0);
        check("pkt_level_peak", 32'(fifo_level), 32'd3);
        check("pkt_head_fwft", 32'(rx_data_flag), 32'h011);
        idle(3, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b0);  // pop on empty must be ignored
        idle(1, 1'b0, 1'b0);
        check("pkt_drained_level", 32'(fifo_level), 32'd0);

        // Time-code, NULL and plain FCT
        send_ctrl(2'd3);
        send_data(8'h45);
        idle(2, 1'b0, 1'b0);
        check("tc_value", 32'(timecode), 32'h45);
        check("tc_no_fifo", 32'(fifo_level), 32'd0);
        check("tc_pulses", 32'(tc_cnt), 32'd1);
        send_ctrl(2'd3);
        send_ctrl(2'd0);
        send_ctrl(2'd0);
        idle(2, 1'b0, 1'b0);
        check("fct_pulses", 32'(fct_cnt), 32'd1);
        check("null_no_fifo", 32'(fifo_level), 32'd0);

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(9'(i));
            send_data(8'(i));
        end
        idle(1, 1'b0, 1'b0);
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_ovf", 32'(rx_overflow), 32'h1);
        idle(1, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);
        check("ovf_cleared", 32'(rx_overflow), 32'h0);
        exp_q.push_back(9'h00A);
        drive(1'b1, 1'b0, 8'h0A, 1'b1, 1'b1, 1'b0);  // write with pop while full
        idle(1, 1'b0, 1'b0);
        check("full_rdwr_level", 32'(fifo_level), 32'd8);
        check("full_rdwr_no_ovf", 32'(rx_overflow), 32'h0);
        idle(8, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);
        check("full_drained", 32'(fifo_level), 32'd0);

        // Parity error: EEP inserted, input ignored until cleared
        exp_q.push_back(9'h101);
        drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        check("par_flag", 32'(rx_error_par), 32'h1);
        check("par_eep_level", 32'(fifo_level), 32'd1);
        send_data(8'h44);
        send_ctrl(2'd3);
        idle(1, 1'b0, 1'b0);
        check("err_ignores", 32'(fifo_level), 32'd1);
        idle(1, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);
        check("par_cleared", 32'(rx_error_par), 32'h0);
        exp_q.push_back(9'h055);
        send_data(8'h55);
        idle(1, 1'b0, 1'b0);
        check("after_clr_level", 32'(fifo_level), 32'd2);
        idle(2, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);

        // ESC then EOP is an escape error
        exp_q.push_back(9'h101);
        send_ctrl(2'd3);
        send_ctrl(2'd1);
        idle(1, 1'b0, 1'b0);
        check("esc_flag", 32'(rx_error_esc), 32'h1);
        check("esc_eep_level", 32'(fifo_level), 32'd1);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b0, 1'b0);
        check("esc_cleared", 32'(rx_error_esc), 32'h0);

        // Time-codes disabled: ESC+data is an escape error
        @(posedge clk); #1; n_valid = 1'b1; n_ctrl = 1'b1; n_code = 8'h03;
        @(posedge clk); #1; n_ctrl = 1'b0; n_code = 8'h10;
        @(posedge clk); #1; n_valid = 1'b0;
        check("notc_esc", 32'(n_esc), 32'h1);
        check("notc_eep", 32'(n_flag), 32'h101);
        check("notc_tc", 32'(n_tc), 32'h0);

        // Parity error while full: overflow instead of EEP
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(9'(8'h81 + i));
            send_data(8'(8'h81 + i));
        end
        drive(1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        check("full_err_par", 32'(rx_error_par), 32'h1);
        check("full_err_ovf", 32'(rx_overflow), 32'h1);
        check("full_err_level", 32'(fifo_level), 32'd8);
        idle(1, 1'b0, 1'b1);
        idle(8, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);
        check("full_err_cleared", 32'({rx_error_par, rx_overflow}), 32'h0);

        // Reset with chars buffered while in ESC_PEND
        for (int i = 0; i < 5; i++) send_data(8'(8'h61 + i));
        send_ctrl(2'd3);
        @(posedge clk); #1; rx_resetn = 1'b0; char_valid = 1'b0;
        @(posedge clk); #1; rx_resetn = 1'b1;
        check("rst2_level", 32'(fifo_level), 32'd0);
        check("rst2_valid", 32'(rx_data_valid), 32'h0);
        check("rst2_flag", 32'(rx_data_flag), 32'h0);
        check("rst2_tc", 32'(timecode), 32'h0);
        exp_q.push_back(9'h077);
        send_data(8'h77);
        idle(1, 1'b0, 1'b0);
        check("rst2_alone_level", 32'(fifo_level), 32'd1);
        check("rst2_tc_still", 32'(timecode), 32'h0);
        idle(1, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
